// File: rtl/sdram_byte_bridge_pkg.sv
// Shared MSX memory-bridge definitions: address widths and the bridge FSM state encoding.
package sdram_byte_bridge_pkg;

  localparam int MEM_BYTE_AW = 25;
  localparam int MEM_WORD_AW = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/sdram_byte_bridge.sv
// Byte-wide slot-decoder requests to a 16-bit toggle req/ack SDRAM controller,
// with a one-word write-through read cache.
module sdram_byte_bridge
  import sdram_byte_bridge_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MEM_BYTE_AW-1:0] addr,
  input  logic [7:0]             din,
  input  logic                   we,
  input  logic                   rd,
  input  logic                   invalidate,
  output logic [7:0]             dout,
  output logic                   ready,
  output logic [MEM_WORD_AW-1:0] mem_addr,
  output logic [15:0]            mem_din,
  output logic [1:0]             mem_be,
  output logic                   mem_we,
  output logic                   mem_req,
  input  logic                   mem_ack,
  input  logic [15:0]            mem_dout,
  output bridge_state_t          state_dbg
);

  // Handshake: a request starts on a rising we/rd edge or an address change while
  // we/rd is held; ready drops the cycle after and returns once mem_ack == mem_req.
  bridge_state_t          state, state_next;
  logic                   we_q, rd_q;
  logic [MEM_BYTE_AW-1:0] addr_q;
  logic [15:0]            cache_word;
  logic [MEM_WORD_AW-1:0] cache_tag;
  logic                   cache_valid;
  logic                   rd_lane;

  logic       addr_changed, start_w, start_r, tag_match, hit, ack_seen;
  logic [7:0] hit_byte, fill_byte;
  logic [15:0] merged_word;

  always_comb begin
    addr_changed = (addr != addr_q);
    start_w      = we && (!we_q || addr_changed);
    start_r      = rd && (!rd_q || addr_changed) && !start_w;
    tag_match    = cache_valid && (cache_tag == addr[MEM_BYTE_AW-1:1]);
    hit          = CACHE_EN && tag_match;
    ack_seen     = (mem_ack == mem_req);
    hit_byte     = addr[0] ? cache_word[15:8] : cache_word[7:0];
    fill_byte    = rd_lane ? mem_dout[15:8] : mem_dout[7:0];
    merged_word  = addr[0] ? {din, cache_word[7:0]} : {cache_word[15:8], din};

    state_next = state;
    case (state)
      IDLE: begin
        if (start_w)                state_next = WR_WAIT;
        else if (start_r && !hit)   state_next = RD_WAIT;
      end
      RD_WAIT: if (ack_seen) state_next = IDLE;
      WR_WAIT: if (ack_seen) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      cache_word  <= '0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
      rd_lane     <= 1'b0;
      dout        <= 8'hFF;
      ready       <= 1'b1;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_be      <= '0;
      mem_we      <= 1'b0;
      mem_req     <= 1'b0;
    end else begin
      state  <= state_next;
      we_q   <= we;
      rd_q   <= rd;
      addr_q <= addr;
      // Placed before the FSM so a fill completing this cycle still wins.
      if (invalidate) cache_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_w) begin
            mem_addr <= addr[MEM_BYTE_AW-1:1];
            mem_din  <= {din, din};
            mem_be   <= addr[0] ? 2'b10 : 2'b01;
            mem_we   <= 1'b1;
            mem_req  <= ~mem_req;
            ready    <= 1'b0;
            if (tag_match) cache_word <= merged_word;
          end else if (start_r) begin
            if (hit) begin
              dout <= hit_byte;
            end else begin
              mem_addr <= addr[MEM_BYTE_AW-1:1];
              mem_be   <= 2'b11;
              mem_we   <= 1'b0;
              mem_req  <= ~mem_req;
              rd_lane  <= addr[0];
              ready    <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (ack_seen) begin
            cache_word  <= mem_dout;
            cache_tag   <= mem_addr;
            cache_valid <= 1'b1;
            dout        <= fill_byte;
            ready       <= 1'b1;
          end
        end
        WR_WAIT: if (ack_seen) ready <= 1'b1;
        default: ready <= 1'b1;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sdram_byte_bridge.sv
// Bench for sdram_byte_bridge: directed cases plus random traffic against a
// memory/cache-hit reference model and a toggle req/ack controller model.
module tb_sdram_byte_bridge;
  import sdram_byte_bridge_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [24:0] addr = '0;
  logic [7:0]  din = '0;
  logic        we = 1'b0, rd = 1'b0, invalidate = 1'b0;
  logic [7:0]  dout;
  logic        ready;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_we, mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dout = '0;
  bridge_state_t state_dbg;

  logic [7:0]  nc_dout;
  logic        nc_ready;
  logic [23:0] nc_mem_addr;
  logic [15:0] nc_mem_din;
  logic [1:0]  nc_mem_be;
  logic        nc_mem_we, nc_mem_req;
  logic        nc_mem_ack = 1'b0;
  logic [15:0] nc_mem_dout = '0;
  bridge_state_t nc_state_dbg;

  sdram_byte_bridge #(.CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .rd(rd),
    .invalidate(invalidate), .dout(dout), .ready(ready), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .state_dbg(state_dbg)
  );

  sdram_byte_bridge #(.CACHE_EN(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .rd(rd),
    .invalidate(invalidate), .dout(nc_dout), .ready(nc_ready), .mem_addr(nc_mem_addr),
    .mem_din(nc_mem_din), .mem_be(nc_mem_be), .mem_we(nc_mem_we), .mem_req(nc_mem_req),
    .mem_ack(nc_mem_ack), .mem_dout(nc_mem_dout), .state_dbg(nc_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference memory and cache model ----------------
  logic [15:0] ref_mem[logic [23:0]];
  logic [15:0] ctl_mem[logic [23:0]];
  bit          m_valid = 1'b0;
  logic [23:0] m_tag = '0;

  function automatic logic [15:0] word_init(input logic [23:0] w);
    return w[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] ref_word(input logic [23:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : word_init(w);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    logic [15:0] w;
    w = ref_word(a[24:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // ---------------- controller models ----------------
  // Main controller samples a new toggle one clock late, then answers ctl_lat clocks after.
  int   ctl_lat = 5;
  int   toggles = 0;
  bit   ctl_busy = 1'b0;
  int   ctl_cnt = 0;
  logic req_seen = 1'b0;
  logic [15:0] ctl_rdata = '0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        ctl_busy = 1'b0; mem_ack = 1'b0; req_seen = 1'b0;
      end else if (mem_req != req_seen) begin
        logic [15:0] w;
        req_seen = mem_req;
        toggles++;
        ctl_busy = 1'b1;
        ctl_cnt = ctl_lat + 1;
        w = ctl_mem.exists(mem_addr) ? ctl_mem[mem_addr] : word_init(mem_addr);
        if (mem_we) begin
          if (mem_be[0]) w[7:0]  = mem_din[7:0];
          if (mem_be[1]) w[15:8] = mem_din[15:8];
          ctl_mem[mem_addr] = w;
        end
        ctl_rdata = w;
      end else if (ctl_busy) begin
        ctl_cnt--;
        if (ctl_cnt == 0) begin
          mem_dout = ctl_rdata;
          mem_ack  = req_seen;
          ctl_busy = 1'b0;
        end
      end
    end
  end

  int   nc_tog = 0;
  logic nc_seen = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        nc_mem_ack = 1'b0; nc_seen = 1'b0;
      end else if (nc_mem_req != nc_seen) begin
        nc_seen = nc_mem_req;
        nc_tog++;
        nc_mem_dout = word_init(nc_mem_addr);
        nc_mem_ack = nc_seen;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output int low, output bit done);
    low = 0; done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready) begin done = 1'b1; break; end
      low++;
    end
  endtask

  task automatic read_op(input logic [24:0] a, input bit hold);
    bit exp_hit, done;
    int tog0, low;
    exp_hit = m_valid && (m_tag == a[24:1]);
    exp_q.push_back(ref_byte(a));
    tog0 = toggles;
    addr = a; rd = 1'b1;
    @(posedge clk);
    wait_ready(low, done);
    check("rd_done", 32'(done), 32'd1);
    check("rd_ready_low", low, exp_hit ? 0 : ctl_lat + 2);
    check("rd_toggles", toggles - tog0, exp_hit ? 0 : 1);
    check("rd_dout", 32'(dout), 32'(exp_q.pop_front()));
    if (!exp_hit) begin m_valid = 1'b1; m_tag = a[24:1]; end
    if (!hold) begin rd = 1'b0; @(negedge clk); end
  endtask

  // Issues a write (optionally with rd rising alongside) and checks the request fields.
  task automatic write_op(input logic [24:0] a, input logic [7:0] d, input bit with_rd);
    bit done;
    int tog0, low, low2;
    logic [15:0] w;
    tog0 = toggles;
    addr = a; din = d; we = 1'b1; rd = with_rd;
    @(posedge clk);
    @(negedge clk);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_be", 32'(mem_be), a[0] ? 32'd2 : 32'd1);
    check("wr_mem_din", 32'(mem_din), 32'({d, d}));
    check("wr_mem_addr", 32'(mem_addr), 32'(a[24:1]));
    low = ready ? 0 : 1;
    if (!ready) begin
      wait_ready(low2, done);
      check("wr_done", 32'(done), 32'd1);
      low += low2;
    end
    check("wr_ready_low", low, ctl_lat + 2);
    check("wr_toggles", toggles - tog0, 1);
    w = ref_word(a[24:1]);
    if (a[0]) w[15:8] = d; else w[7:0] = d;
    ref_mem[a[24:1]] = w;
    we = 1'b0; rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_invalidate();
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    m_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [23:0] pool[6];
  initial begin
    int t0;
    logic [15:0] w;
    pool = '{24'h000000, 24'h000001, 24'h000002, 24'h000008, 24'h000800, 24'hFFFFFF};
    ref_mem[24'h000008] = 16'hA55A;
    ctl_mem[24'h000008] = 16'hA55A;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_dout", 32'(dout), 32'hFF);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    ctl_lat = 5;
    read_op(25'h000010, 1'b0);
    read_op(25'h000011, 1'b0);
    write_op(25'h000011, 8'h3C, 1'b0);
    read_op(25'h000011, 1'b0);
    read_op(25'h000010, 1'b1);
    read_op(25'h000011, 1'b0);
    pulse_invalidate();
    read_op(25'h000010, 1'b0);
    ctl_lat = 3;
    write_op(25'h000100, 8'h77, 1'b1);
    write_op(25'h1FFFFFF, 8'hA7, 1'b0);
    check("wrap_be", 32'(mem_be), 32'd2);
    read_op(25'h1FFFFFF, 1'b0);
    read_op(25'h1FFFFFE, 1'b0);

    // Reset while a fill is outstanding.
    ctl_lat = 5;
    addr = 25'h000200; rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_state", 32'(state_dbg), 32'(RD_WAIT));
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_dout", 32'(dout), 32'hFF);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    rd = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_op(25'h000010, 1'b0);

    // Uncached instance: two reads of one word, two requests.
    repeat (6) @(negedge clk);
    t0 = nc_tog;
    ctl_lat = 1;
    read_op(25'h000080, 1'b0);
    repeat (4) @(negedge clk);
    w = word_init(24'h000040);
    check("nc_dout_lo", 32'(nc_dout), 32'(w[7:0]));
    read_op(25'h000081, 1'b0);
    repeat (4) @(negedge clk);
    check("nc_dout_hi", 32'(nc_dout), 32'(w[15:8]));
    check("nc_toggles", nc_tog - t0, 2);

    for (int n = 0; n < 60; n++) begin
      int op;
      logic [24:0] a;
      op = $urandom_range(0, 9);
      a = {pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1))};
      ctl_lat = $urandom_range(1, 6);
      if (op < 6)       read_op(a, 1'b0);
      else if (op < 9)  write_op(a, 8'($urandom_range(0, 255)), 1'b0);
      else              pulse_invalidate();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_byte_bridge.md
# sdram_byte_bridge

Responder end of the slot decoder's byte-wide memory request interface. Accepts level-held 8-bit read/write requests with a 25-bit byte address and a `ready` handshake, and converts them to a 16-bit word controller that uses toggle req/ack. Holds a one-word read cache so repeated byte reads within a word skip the controller. Sits between the slot decoder and the SDRAM controller inside the MSX core.

## Interface
- `CACHE_EN`, default 1: enables the one-word read cache; 0 sends every read to the controller.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `addr`  in  25  byte address from the slot decoder.
- `din`  in  8  write data.
- `we`  in  1  write request level; held for the whole CPU write cycle.
- `rd`  in  1  read request level; held for the whole CPU read cycle.
- `invalidate`  in  1  one-cycle pulse that clears cache valid, e.g. after a ROM upload.
- `dout`  out  8  read data byte, selected by `addr[0]`.
- `ready`  out  1  high when no access is outstanding.
- `mem_addr`  out  24  word address, equal to `addr[24:1]`.
- `mem_din`  out  16  write word; `din` is replicated to both lanes.
- `mem_be`  out  2  byte enables; bit0 is the low byte (even address).
- `mem_we`  out  1  1 = write, 0 = read; qualifies each request.
- `mem_req`  out  1  toggle; each change is one request.
- `mem_ack`  in  1  toggle; equals `mem_req` when the request is complete.
- `mem_dout`  in  16  read word; valid when `mem_ack` equals `mem_req`.

## Operation
- Request start: a rising edge of `we` or `rd` (1-cycle registered history), or a change of `addr` while `we` or `rd` stays high.
- If `we` and `rd` start together, `we` wins and `rd` is ignored for that cycle.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, read start, cache hit (valid and `tag == addr[24:1]`, `CACHE_EN`=1):
  - no controller request;
  - `dout` updates on the next clock;
  - `ready` stays 1.
- IDLE, read start, miss:
  - latch the address;
  - `mem_we`=0, `mem_be`=2'b11;
  - toggle `mem_req`;
  - go to RD_WAIT.
- RD_WAIT, when `mem_ack == mem_req`:
  - cache word ← `mem_dout`, tag ← latched address, valid ← 1;
  - `dout` ← selected byte;
  - return to IDLE.
- IDLE, write start:
  - `mem_we`=1, `mem_be` = `addr[0] ? 2'b10 : 2'b01`;
  - toggle `mem_req`;
  - if the cache tag matches, merge `din` into the addressed lane in the same cycle (write-through);
  - go to WR_WAIT.
- WR_WAIT, when `mem_ack == mem_req`: return to IDLE.
- Request starts seen outside IDLE are dropped. The slot decoder holds the CPU in wait while `ready`=0, so none are legal.
- `invalidate` clears valid in any state. If it arrives during RD_WAIT, the fill still completes and sets valid (the fill data is newer).
- Outputs are held stable from the request toggle until the matching ack.

## Timing
- Reset values:
  - state IDLE, `ready`=1;
  - `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_din`=0;
  - `dout`=8'hFF, cache valid=0, tag=0.
- `ready` is registered: it falls the cycle after the start edge and rises the cycle after ack is seen. Consumers ignore `ready` in the start-edge cycle.
- Hit latency: 1 clk to `dout`.
- Miss latency: 2 clk plus controller latency.
- Write occupancy: 2 clk plus controller latency.
- The controller shares `reset`, so after reset `mem_ack`=0 matches `mem_req`. An ack arriving mid-operation across a reset is lost by design.
- Address wrap: `addr` 25'h1FFFFFF maps to word 24'hFFFFFF, lane 1. No carry.

## Structure
- State enum `bridge_state_t` and width constants (`MEM_BYTE_AW`=25, `MEM_WORD_AW`=24) go in the shared MSX package.
- Single module, no sub-module. Edge detection, cache register and FSM live in one always block, plus combinational lane select.

## Test plan
- Reset, then read 25'h000010 with the model returning 16'hA55A after 5 clk:
  - exactly one `mem_req` toggle;
  - `dout`=8'h5A;
  - `ready` low for 7 clk.
- Then read 25'h000011: no toggle, `dout`=8'hA5 after 1 clk, `ready` stays 1.
- Write 8'h3C to 25'h000011: `mem_be`=2'b10 and `mem_din`=16'h3C3C. A following read of 25'h000011 hits and returns 8'h3C.
- `invalidate` pulse, then read 25'h000010: miss, one toggle.
- `rd` and `we` rise in the same cycle: one write request only, `mem_we`=1.
- Assert `reset` during RD_WAIT:
  - `ready`=1, `dout`=8'hFF, valid=0 immediately;
  - the next read misses.
- `CACHE_EN`=0: two reads of the same word give two toggles.
